fetch_sequencer: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction decoder.
- Holds the program counter and reads 16-bit words from program memory through a request/valid handshake.
- Presents each word on `instruction` and pulses `IRin` for exactly one cycle so the decoder latches it.
- Waits for the execution stage to report completion, then advances the PC (sequential or branch) and fetches again.

---
 rtl/fetch_sequencer_pkg.sv | 27 ++
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_sequencer_pc_unit.sv | 28 ++
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch stage and the instruction decoder:
//   bus widths, the HALT opcode, the fetch FSM state encoding and an
//   opcode helper.
//   No ports (package).
package fetch_sequencer_pkg;

    localparam int ADDR_W          = 8;
    localparam int INSTR_W         = 16;
    localparam int DEF_MEM_TIMEOUT = 15;

    localparam logic [3:0] OPC_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Groups the fetch stage's memory handshake, decoder handoff, execution
//   feedback and status signals.
//   master : the fetch sequencer (drives mem_rd/mem_addr, instruction/IRin,
//            pc, retired, halted, fault)
//   slave  : the surrounding system (drives run, mem_rdata/mem_valid,
//            exec_done, branch_en, branch_target)
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic               run;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_valid;
    logic [INSTR_W-1:0] instruction;
    logic               IRin;
    logic               exec_done;
    logic               branch_en;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  pc;
    logic [15:0]        retired;
    logic               halted;
    logic               fault;

    modport master (
        input  run, mem_rdata, mem_valid, exec_done, branch_en, branch_target,
        output mem_rd, mem_addr, instruction, IRin, pc, retired, halted, fault
    );

    modport slave (
        output run, mem_rdata, mem_valid, exec_done, branch_en, branch_target,
        input  mem_rd, mem_addr, instruction, IRin, pc, retired, halted, fault
    );

endinterface

// File: rtl/fetch_sequencer_pc_unit.sv
// fetch_sequencer_pc_unit
//   Program counter register with sequential/branch next-address select.
//   clk, rst_n     : clock, async active-low reset (pc -> 0)
//   advance        : one-cycle strobe when the current instruction retires
//   branch_en      : selects branch_target instead of pc+1 on advance
//   branch_target  : branch destination
//   pc             : current program counter
module fetch_sequencer_pc_unit
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc
);

    // pc + 1 is kept at ADDR_W bits so the top address wraps to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (advance) begin
            pc <= branch_en ? branch_target : pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch stage: reads words from program memory at pc,
//   hands each one to the decoder with a one-cycle IRin strobe, waits for
//   the execution stage, then advances pc and fetches again.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_sequencer_if master modport (memory handshake,
//                decoder handoff, exec feedback, status)
//
//   state | meaning
//   IDLE  | quiet; leaves when run=1
//   FETCH | one-cycle mem_rd at pc; reloads the memory timeout timer
//   WAIT  | waiting for mem_valid; fault after MEM_TIMEOUT cycles
//   LOAD  | one-cycle IRin; HALT opcode stops here
//   EXEC  | waiting for exec_done; retires and advances pc
//   HALT  | halted=1; leaves only through reset
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   tmr;
    logic [INSTR_W-1:0] instr_q;
    logic [15:0]        retired_q;
    logic               fault_q;
    logic [ADDR_W-1:0]  pc;
    logic               load_instr;
    logic               set_fault;
    logic               retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_instr = 1'b0;
        set_fault  = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_valid) begin
                    load_instr = 1'b1;
                    state_nxt  = ST_LOAD;
                end else if (tmr == '0) begin
                    set_fault = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_LOAD: begin
                state_nxt = is_halt(instr_q) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    retire    = 1'b1;
                    state_nxt = bus.run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The timer counts down from MEM_TIMEOUT-1 so that its zero value marks
    // the last WAIT cycle in which mem_valid is still accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr       <= '0;
            instr_q   <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (state == ST_FETCH) begin
                tmr <= TMR_W'(MEM_TIMEOUT - 1);
            end else if (state == ST_WAIT && tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
            if (load_instr) instr_q <= bus.mem_rdata;
            if (set_fault) fault_q <= 1'b1;
            if (retire && retired_q != 16'hFFFF) retired_q <= retired_q + 1'b1;
        end
    end

    fetch_sequencer_pc_unit u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance       (retire),
        .branch_en     (bus.branch_en),
        .branch_target (bus.branch_target),
        .pc            (pc)
    );

    assign bus.mem_rd      = (state == ST_FETCH);
    assign bus.mem_addr    = pc;
    assign bus.IRin        = (state == ST_LOAD);
    assign bus.instruction = instr_q;
    assign bus.pc          = pc;
    assign bus.retired     = retired_q;
    assign bus.halted      = (state == ST_HALT);
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer: a per-cycle vector table for the
//   main fetch/execute/branch/wrap/idle/halt flow, plus hand-written
//   sequences for the memory timeout and asynchronous reset cases.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int TIMEOUT_CYC = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_sequencer_if bus();

    fetch_sequencer #(.MEM_TIMEOUT(TIMEOUT_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        valid;
        logic [15:0] rdata;
        logic        done;
        logic        br;
        logic [7:0]  tgt;
        logic        rd;
        logic [7:0]  addr;
        logic        irin;
        logic [15:0] instr;
        logic [7:0]  pc;
        logic [15:0] ret;
        logic        halt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic run, input logic valid, input logic [15:0] rdata,
                         input logic done, input logic br, input logic [7:0] tgt);
        bus.run           = run;
        bus.mem_valid     = valid;
        bus.mem_rdata     = rdata;
        bus.exec_done     = done;
        bus.branch_en     = br;
        bus.branch_target = tgt;
    endtask

    task automatic add(input logic run, input logic valid, input logic [15:0] rdata,
                       input logic done, input logic br, input logic [7:0] tgt,
                       input logic rd, input logic [7:0] addr, input logic irin,
                       input logic [15:0] instr, input logic [7:0] pc,
                       input logic [15:0] ret, input logic halt);
        vec_t t;
        t = '{run, valid, rdata, done, br, tgt, rd, addr, irin, instr, pc, ret, halt};
        vecs.push_back(t);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_rd"},  {15'd0, bus.mem_rd}, 16'd0);
        chk({tag, " IRin"},    {15'd0, bus.IRin},   16'd0);
        chk({tag, " instr"},   bus.instruction,     16'h0000);
        chk({tag, " pc"},      {8'd0, bus.pc},      16'd0);
        chk({tag, " retired"}, bus.retired,         16'd0);
        chk({tag, " halted"},  {15'd0, bus.halted}, 16'd0);
        chk({tag, " fault"},   {15'd0, bus.fault},  16'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // valid_at = 0: memory never answers; otherwise answer in that WAIT cycle.
    task automatic wait_limit(input int valid_at);
        string tag;
        tag = $sformatf("tmo%0d", valid_at);
        do_reset();
        bus.run = 1'b1;
        @(negedge clk);
        chk({tag, " fetch mem_rd"}, {15'd0, bus.mem_rd}, 16'd1);
        for (int w = 1; w <= TIMEOUT_CYC; w++) begin
            @(negedge clk);
            bus.mem_valid = (w == valid_at);
            bus.mem_rdata = 16'hA5A5;
            chk($sformatf("%s w%0d fault", tag, w), {15'd0, bus.fault}, 16'd0);
            chk($sformatf("%s w%0d IRin", tag, w), {15'd0, bus.IRin}, 16'd0);
            chk($sformatf("%s w%0d mem_rd", tag, w), {15'd0, bus.mem_rd}, 16'd0);
        end
        @(negedge clk);
        bus.mem_valid = 1'b0;
        if (valid_at == 0) begin
            chk({tag, " fault"},  {15'd0, bus.fault},  16'd1);
            chk({tag, " halted"}, {15'd0, bus.halted}, 16'd1);
            for (int k = 0; k < 5; k++) begin
                drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 8'h44);
                @(negedge clk);
                chk($sformatf("%s hold%0d halted", tag, k), {15'd0, bus.halted}, 16'd1);
                chk($sformatf("%s hold%0d fault", tag, k), {15'd0, bus.fault}, 16'd1);
                chk($sformatf("%s hold%0d IRin", tag, k), {15'd0, bus.IRin}, 16'd0);
                chk($sformatf("%s hold%0d mem_rd", tag, k), {15'd0, bus.mem_rd}, 16'd0);
                chk($sformatf("%s hold%0d instr", tag, k), bus.instruction, 16'h0000);
                chk($sformatf("%s hold%0d pc", tag, k), {8'd0, bus.pc}, 16'd0);
            end
        end else begin
            chk({tag, " IRin"},  {15'd0, bus.IRin},  16'd1);
            chk({tag, " instr"}, bus.instruction,    16'hA5A5);
            chk({tag, " fault"}, {15'd0, bus.fault}, 16'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //  run vld rdata     dn br tgt    | rd addr  ir instr     pc     ret halt
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h00, 0, 16'h0000, 8'h00, 0, 0); // IDLE
        add(1, 0, 16'h0000, 0, 0, 8'h00,   1, 8'h00, 0, 16'h0000, 8'h00, 0, 0); // FETCH
        add(1, 1, 16'h1002, 0, 0, 8'h00,   0, 8'h00, 0, 16'h0000, 8'h00, 0, 0); // WAIT
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h00, 1, 16'h1002, 8'h00, 0, 0); // LOAD
        add(1, 0, 16'h0000, 1, 0, 8'h00,   0, 8'h00, 0, 16'h1002, 8'h00, 0, 0); // EXEC
        add(1, 0, 16'h0000, 0, 0, 8'h00,   1, 8'h01, 0, 16'h1002, 8'h01, 1, 0); // FETCH
        add(1, 1, 16'h523F, 0, 0, 8'h00,   0, 8'h01, 0, 16'h1002, 8'h01, 1, 0); // WAIT
        add(1, 0, 16'h0000, 1, 1, 8'h33,   0, 8'h01, 1, 16'h523F, 8'h01, 1, 0); // LOAD, stray done
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h01, 0, 16'h523F, 8'h01, 1, 0); // EXEC
        add(1, 0, 16'h0000, 1, 1, 8'h20,   0, 8'h01, 0, 16'h523F, 8'h01, 1, 0); // EXEC branch
        add(1, 0, 16'h0000, 0, 0, 8'h00,   1, 8'h20, 0, 16'h523F, 8'h20, 2, 0); // FETCH
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h20, 0, 16'h523F, 8'h20, 2, 0); // WAIT
        add(1, 1, 16'h0123, 0, 0, 8'h00,   0, 8'h20, 0, 16'h523F, 8'h20, 2, 0); // WAIT
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h20, 1, 16'h0123, 8'h20, 2, 0); // LOAD
        add(1, 0, 16'h0000, 1, 1, 8'hFF,   0, 8'h20, 0, 16'h0123, 8'h20, 2, 0); // EXEC branch FF
        add(1, 0, 16'h0000, 0, 0, 8'h00,   1, 8'hFF, 0, 16'h0123, 8'hFF, 3, 0); // FETCH
        add(1, 1, 16'h4444, 0, 0, 8'h00,   0, 8'hFF, 0, 16'h0123, 8'hFF, 3, 0); // WAIT
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'hFF, 1, 16'h4444, 8'hFF, 3, 0); // LOAD
        add(1, 0, 16'h0000, 1, 0, 8'h00,   0, 8'hFF, 0, 16'h4444, 8'hFF, 3, 0); // EXEC seq
        add(1, 0, 16'h0000, 0, 0, 8'h00,   1, 8'h00, 0, 16'h4444, 8'h00, 4, 0); // FETCH wrapped
        add(0, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h00, 0, 16'h4444, 8'h00, 4, 0); // WAIT run drop
        add(0, 1, 16'h2222, 0, 0, 8'h00,   0, 8'h00, 0, 16'h4444, 8'h00, 4, 0); // WAIT
        add(0, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h00, 1, 16'h2222, 8'h00, 4, 0); // LOAD
        add(0, 0, 16'h0000, 1, 0, 8'h00,   0, 8'h00, 0, 16'h2222, 8'h00, 4, 0); // EXEC
        add(0, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h01, 0, 16'h2222, 8'h01, 5, 0); // IDLE
        add(0, 1, 16'hFFFF, 1, 1, 8'h55,   0, 8'h01, 0, 16'h2222, 8'h01, 5, 0); // IDLE stray
        add(0, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h01, 0, 16'h2222, 8'h01, 5, 0); // IDLE
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h01, 0, 16'h2222, 8'h01, 5, 0); // IDLE run
        add(1, 0, 16'h0000, 0, 0, 8'h00,   1, 8'h01, 0, 16'h2222, 8'h01, 5, 0); // FETCH
        add(1, 1, 16'hF000, 0, 0, 8'h00,   0, 8'h01, 0, 16'h2222, 8'h01, 5, 0); // WAIT
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h01, 1, 16'hF000, 8'h01, 5, 0); // LOAD halt op
        add(1, 1, 16'h1234, 1, 0, 8'h00,   0, 8'h01, 0, 16'hF000, 8'h01, 5, 1); // HALT
        add(1, 0, 16'h0000, 0, 0, 8'h00,   0, 8'h01, 0, 16'hF000, 8'h01, 5, 1); // HALT

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].valid, vecs[i].rdata,
                  vecs[i].done, vecs[i].br, vecs[i].tgt);
            chk($sformatf("v%0d mem_rd", i), {15'd0, bus.mem_rd}, {15'd0, vecs[i].rd});
            if (vecs[i].rd)
                chk($sformatf("v%0d mem_addr", i), {8'd0, bus.mem_addr}, {8'd0, vecs[i].addr});
            chk($sformatf("v%0d IRin", i), {15'd0, bus.IRin}, {15'd0, vecs[i].irin});
            chk($sformatf("v%0d instr", i), bus.instruction, vecs[i].instr);
            chk($sformatf("v%0d pc", i), {8'd0, bus.pc}, {8'd0, vecs[i].pc});
            chk($sformatf("v%0d retired", i), bus.retired, vecs[i].ret);
            chk($sformatf("v%0d halted", i), {15'd0, bus.halted}, {15'd0, vecs[i].halt});
            chk($sformatf("v%0d fault", i), {15'd0, bus.fault}, 16'd0);
            @(negedge clk);
        end

        wait_limit(0);
        wait_limit(TIMEOUT_CYC);

        // Asynchronous reset while the second instruction sits in EXEC.
        do_reset();
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.mem_valid = 1'b1; bus.mem_rdata = 16'h1002;
        @(negedge clk); bus.mem_valid = 1'b0;
        @(negedge clk); bus.exec_done = 1'b1;
        @(negedge clk); bus.exec_done = 1'b0;
        @(negedge clk); bus.mem_valid = 1'b1; bus.mem_rdata = 16'h7777;
        @(negedge clk); bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("exec pre-rst pc",      {8'd0, bus.pc}, 16'd1);
        chk("exec pre-rst retired", bus.retired,    16'd1);
        chk("exec pre-rst instr",   bus.instruction, 16'h7777);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst in exec");

        // Asynchronous reset while IRin is high.
        @(negedge clk);
        rst_n = 1'b1;
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.mem_valid = 1'b1; bus.mem_rdata = 16'h3456;
        @(negedge clk); bus.mem_valid = 1'b0;
        chk("load pre-rst IRin", {15'd0, bus.IRin}, 16'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst in load");
        @(posedge clk); #1;
        chk("rst in load next IRin", {15'd0, bus.IRin}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
